// File: rtl/motion_scheduler.sv
// motion_scheduler: frame-based round-robin step scheduler for four moving objects,
// each stepping once every period+1 frames while enabled.
module motion_scheduler #(
  parameter int PERIOD_W = 4,
  parameter int DEFAULT_PERIOD = 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                tick,
  input  logic                pause,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_idx,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_en,
  input  logic                ovr_clr,
  output logic [3:0]          step,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_nx;
  logic tick_q, rise, visit, fire;
  logic [1:0] idx;
  logic [3:0] en;
  logic [PERIOD_W-1:0] period [4];
  logic [PERIOD_W-1:0] cnt [4];
  assign rise = tick & ~tick_q;
  assign visit = state == SCAN;
  assign busy = visit;
  // A config write to the object under visit suppresses its step this cycle.
  assign fire = visit & en[idx] & cnt[idx] == '0 & ~(cfg_we & cfg_idx == idx);
  assign step = fire ? 4'b1 << idx : 4'b0;
  always_comb begin
    state_nx = visit ? (idx == 2'd3 ? IDLE : SCAN) : (rise & ~pause ? SCAN : IDLE);
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      idx <= '0;
      tick_q <= 1'b1;
      frame_done <= 1'b0;
      overrun <= 1'b0;
      en <= 4'b0001;
      for (int i = 0; i < 4; i++) begin
        period[i] <= PERIOD_W'(DEFAULT_PERIOD);
        cnt[i] <= PERIOD_W'(DEFAULT_PERIOD);
      end
    end else begin
      state <= state_nx;
      tick_q <= tick;
      idx <= visit ? idx + 2'd1 : 2'd0;
      frame_done <= visit & idx == 2'd3;
      overrun <= (rise & visit) | (overrun & ~ovr_clr);
      if (visit & en[idx])
        cnt[idx] <= cnt[idx] == '0 ? period[idx] : cnt[idx] - PERIOD_W'(1);
      // Later assignment lets a config write override the visit update.
      if (cfg_we) begin
        period[cfg_idx] <= cfg_period;
        en[cfg_idx] <= cfg_en;
        cnt[cfg_idx] <= cfg_period;
      end
    end
  end
endmodule

// File: tb/tb_motion_scheduler.sv
// tb_motion_scheduler: directed and randomized frames checked against a per-object
// countdown model of the scheduling rules.
module tb_motion_scheduler;
  logic clk = 1'b0, clr = 1'b0, tick = 1'b0, pause = 1'b0, cfg_we = 1'b0;
  logic cfg_en = 1'b0, ovr_clr = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [3:0] cfg_period = '0;
  logic [3:0] step;
  logic busy, frame_done, overrun;
  int checks = 0, errors = 0;
  int per_m[4], cnt_m[4];
  bit en_m[4];
  bit ovr_m, clr_with_rise;

  always #5 clk = ~clk;

  motion_scheduler #(.PERIOD_W(4), .DEFAULT_PERIOD(1)) dut (
    .clk(clk), .clr(clr), .tick(tick), .pause(pause), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_period(cfg_period), .cfg_en(cfg_en), .ovr_clr(ovr_clr),
    .step(step), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      per_m[i] = 1;
      cnt_m[i] = 1;
      en_m[i] = (i == 0);
    end
    ovr_m = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      next();
      tick = 1'b0;
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_step", step, 0);
      chk("idle_frame_done", frame_done, 0);
      chk("idle_overrun", overrun, ovr_m);
    end
  endtask

  task automatic cfg_idle(input int j, input int p, input bit e);
    next();
    cfg_we = 1'b1;
    cfg_idx = 2'(j);
    cfg_period = 4'(p);
    cfg_en = e;
    #1;
    chk("cfg_idle_step", step, 0);
    next();
    cfg_we = 1'b0;
    per_m[j] = p;
    cnt_m[j] = p;
    en_m[j] = e;
  endtask

  task automatic clear_ovr();
    next();
    ovr_clr = 1'b1;
    #1;
    chk("ovr_before_clear", overrun, ovr_m);
    next();
    ovr_clr = 1'b0;
    ovr_m = 0;
    #1;
    chk("ovr_cleared", overrun, 0);
  endtask

  // One frame: rise at T, visits at T+1..T+4, frame_done at T+5.
  task automatic frame(input int rise2_at, input int pause_at, input int cfg_at,
                       input int cfg_j, input int cfg_p, input bit cfg_e);
    logic [3:0] exp;
    next();
    tick = 1'b1;
    #1;
    chk("start_busy", busy, 0);
    chk("start_step", step, 0);
    chk("start_overrun", overrun, ovr_m);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = k - 1;
      next();
      tick = (k == rise2_at);
      pause = (pause_at > 0 && k >= pause_at);
      ovr_clr = clr_with_rise && k == rise2_at;
      cfg_we = (k == cfg_at);
      cfg_idx = 2'(cfg_j);
      cfg_period = 4'(cfg_p);
      cfg_en = cfg_e;
      #1;
      exp = '0;
      if (!(k == cfg_at && cfg_j == i) && en_m[i]) begin
        if (cnt_m[i] == 0) begin
          exp = 4'b1 << i;
          cnt_m[i] = per_m[i];
        end else cnt_m[i]--;
      end
      chk("scan_step", step, exp);
      chk("scan_busy", busy, 1);
      chk("scan_frame_done", frame_done, 0);
      chk("scan_overrun", overrun, ovr_m);
      if (k == cfg_at) begin
        per_m[cfg_j] = cfg_p;
        cnt_m[cfg_j] = cfg_p;
        en_m[cfg_j] = cfg_e;
      end
      if (k == rise2_at) ovr_m = 1;
    end
    next();
    tick = 1'b0;
    cfg_we = 1'b0;
    ovr_clr = 1'b0;
    pause = 1'b0;
    #1;
    chk("end_busy", busy, 0);
    chk("end_frame_done", frame_done, 1);
    chk("end_step", step, 0);
    chk("end_overrun", overrun, ovr_m);
  endtask

  initial begin
    int r2, ca;
    clr_with_rise = 0;
    model_reset();
    clr = 1'b0;
    tick = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_step", step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    clr = 1'b1;
    next();
    #1;
    chk("tick_high_at_release", busy, 0);
    next();
    #1;
    chk("tick_high_no_rise", busy, 0);
    idle(2);

    // Defaults: obj0 steps on frames 2 and 4 only.
    repeat (4) begin
      frame(0, 0, 0, 0, 0, 0);
      idle(14);
    end

    // obj2 period 0: steps every frame.
    cfg_idle(2, 0, 1);
    repeat (3) begin
      frame(0, 0, 0, 0, 0, 0);
      idle(3);
    end

    // Second rise during scan sets a sticky overrun.
    frame(2, 0, 0, 0, 0, 0);
    idle(5);
    clear_ovr();
    frame(4, 0, 0, 0, 0, 0);
    idle(2);
    clear_ovr();

    // Set wins over a simultaneous clear.
    clr_with_rise = 1;
    frame(3, 0, 0, 0, 0, 0);
    clr_with_rise = 0;
    idle(2);
    clear_ovr();

    // Paused rise is discarded; pause raised mid-scan is ignored.
    next();
    pause = 1'b1;
    tick = 1'b1;
    #1;
    chk("pause_rise_busy", busy, 0);
    idle(4);
    pause = 1'b0;
    frame(0, 2, 0, 0, 0, 0);
    idle(2);

    // Config write to obj1 during its own visit.
    frame(0, 0, 2, 1, 3, 1);
    repeat (4) begin
      idle(2);
      frame(0, 0, 0, 0, 0, 0);
    end
    idle(2);

    // Randomized configs, overlapping rises and mid-scan config writes.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) cfg_idle($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      r2 = $urandom_range(1, 4);
      if (r2 == 1) r2 = 0;
      ca = $urandom_range(0, 4);
      frame(r2, 0, ca, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      idle($urandom_range(1, 4));
      if (ovr_m && $urandom_range(0, 1) == 1) clear_ovr();
    end

    // Reset mid-scan aborts with no further pulses and restores defaults.
    cfg_idle(3, 0, 1);
    frame(2, 0, 0, 0, 0, 0);
    idle(1);
    next();
    tick = 1'b1;
    next();
    tick = 1'b0;
    next();
    clr = 1'b0;
    #1;
    chk("abort_step", step, 0);
    chk("abort_busy", busy, 0);
    chk("abort_frame_done", frame_done, 0);
    chk("abort_overrun", overrun, 0);
    next();
    #1;
    chk("abort_hold_frame_done", frame_done, 0);
    chk("abort_hold_busy", busy, 0);
    clr = 1'b1;
    model_reset();
    idle(4);
    repeat (2) begin
      frame(0, 0, 0, 0, 0, 0);
      idle(2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/motion_scheduler.md
MOTION_SCHEDULER -- requirements
Module: motion_scheduler

Interface
REQ-001 Parameter PERIOD_W, default 4: width of each per-object step period and countdown.
REQ-002 Parameter DEFAULT_PERIOD, default 1: period and countdown value loaded at reset for all objects.
REQ-003 clk  input  1  system clock; all state updates occur on rising edge only.
REQ-004 clr  input  1  reset, asynchronous assert, active-low; the block SHALL reset whenever clr==0.
REQ-005 tick  input  1  cursor-rate clock level, synchronous to clk; each rising edge starts one scheduling frame.
REQ-006 pause  input  1  level; when 1, new frames are not started.
REQ-007 cfg_we  input  1  one-cycle config write strobe.
REQ-008 cfg_idx  input  2  object index targeted by a config write.
REQ-009 cfg_period  input  PERIOD_W  new step period for the object (0 = step every frame).
REQ-010 cfg_en  input  1  new enable for the object.
REQ-011 ovr_clr  input  1  clears the overrun flag.
REQ-012 step  output  4  one-hot, one-cycle step enable per object, driving the position-update datapath of objects 0..3.
REQ-013 busy  output  1  high while a frame scan is in progress.
REQ-014 frame_done  output  1  one-cycle pulse at end of each frame scan.
REQ-015 overrun  output  1  sticky flag: a tick rising edge arrived while busy.

Function
REQ-016 Edge detect: the block SHALL register tick into tick_q each cycle; rise = tick & ~tick_q.
REQ-017 FSM states: IDLE and SCAN.
REQ-018 In IDLE, rise with pause==0 SHALL move to SCAN with idx=0 and busy=1 from the next cycle.
REQ-019 In IDLE, rise with pause==1 SHALL be discarded, with no state change and no flag set.
REQ-020 SCAN SHALL visit one object per cycle, in order idx=0,1,2,3.
REQ-021 Per visited object with en==1: if cnt==0, assert step[idx] that cycle and reload cnt<=period[idx]; else cnt<=cnt-1 and no step.
REQ-022 Visited object with en==0: no step; cnt held.
REQ-023 After idx==3 is visited, the FSM SHALL return to IDLE; busy=0 and frame_done=1 for exactly one cycle on that transition.
REQ-024 Latency: with rise seen in cycle T, step[i] SHALL be eligible in cycle T+1+i, and frame_done SHALL be in cycle T+5.
REQ-025 At most one step bit SHALL be high in any cycle.
REQ-026 A rise while in SCAN SHALL be dropped and SHALL set overrun=1; the scan in progress continues unaffected.
REQ-027 ovr_clr==1 SHALL clear overrun; if ovr_clr and a new overrun event occur in the same cycle, set wins.
REQ-028 A change of pause during SCAN SHALL NOT alter the scan in progress.
REQ-029 A config write SHALL load period[cfg_idx]<=cfg_period, en[cfg_idx]<=cfg_en and cnt[cfg_idx]<=cfg_period, in any state.
REQ-030 A config write targeting the object being visited in that SCAN cycle SHALL win: no step for that object that cycle, and the config values are stored.
REQ-031 Countdown arithmetic SHALL be unsigned PERIOD_W-bit; cnt never decrements below 0.

Reset
REQ-032 On clr==0: state=IDLE, idx=0, step=0, busy=0, frame_done=0, overrun=0, period[all]=DEFAULT_PERIOD, cnt[all]=DEFAULT_PERIOD, en=4'b0001.
REQ-033 tick_q SHALL reset to 1, so a tick already high at reset release is not treated as a rise.
REQ-034 Reset asserted mid-SCAN SHALL abort the scan immediately, with no further step or frame_done pulses.

Verification
REQ-035 Reset defaults, then 4 tick rises spaced 20 cycles apart -> step[0] pulses on frames 2 and 4 only, since cnt starts at 1 and reloads to 1; step[3:1] never pulse.
REQ-036 Write obj2 period=0, en=1, then tick rise at cycle T -> step[2] high at T+3 every frame; frame_done at T+5; busy high from T+1 through T+4.
REQ-037 Tick rise 2 cycles after a previous rise -> second rise dropped, overrun=1 and held; ovr_clr pulse -> overrun=0.
REQ-038 pause=1 then tick rise -> no busy, no step, no overrun; pause=1 asserted at T+2 of an active scan -> scan completes with frame_done at T+5.
REQ-039 Config write to obj1 with period=3 landing in cycle T+2, the visit cycle of obj1 -> no step[1] that cycle; cnt[1]=3, and obj1 steps on the 4th following frame.
REQ-040 clr pulsed low at T+2 of a scan -> step=0 and busy=0 immediately, no frame_done; all registers at reset values.
